apu_req_issuer: RTL

Core-side initiator for the shared APU/FPU request/response protocol. It accepts FP operations from the core's dispatch stage and issues them on the APU master port (req/gnt request channel, rvalid/rID response channel) toward the FPU interconnect and the FPnew-based responders. It tags each operation with a slot ID, tolerates out-of-order responses, and retires results to writeback in issue order through a small reorder buffer.

---
 rtl/apu_pkg.sv | 35 +++
 rtl/apu_rob.sv | 118 +++++++++++
 rtl/apu_req_issuer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/apu_pkg.sv
// Shared definitions for the APU request/response protocol.
// Holds the field widths shared with the responder wrapper, the slot index
// type, and the helpers that compose a transaction tag from
// {core id, slot} and split it back apart.
package apu_pkg;

   localparam int unsigned ID_WIDTH        = 9;
   localparam int unsigned NB_ARGS         = 2;
   localparam int unsigned OPCODE_WIDTH    = 6;
   localparam int unsigned DATA_WIDTH      = 32;
   localparam int unsigned FLAGS_IN_WIDTH  = 15;
   localparam int unsigned FLAGS_OUT_WIDTH = 5;
   localparam int unsigned MAX_OUTSTANDING = 4;

   localparam int unsigned SLOT_W = $clog2(MAX_OUTSTANDING);
   localparam int unsigned CORE_W = ID_WIDTH - SLOT_W;

   typedef logic [SLOT_W-1:0]   slot_t;
   typedef logic [SLOT_W:0]     cnt_t;
   typedef logic [CORE_W-1:0]   core_t;
   typedef logic [ID_WIDTH-1:0] tag_t;

   function automatic tag_t tag_compose(input core_t core, input slot_t slot);
      return {core, slot};
   endfunction

   function automatic slot_t tag_slot(input tag_t tag);
      return tag[SLOT_W-1:0];
   endfunction

   function automatic core_t tag_core(input tag_t tag);
      return tag[ID_WIDTH-1:SLOT_W];
   endfunction

endpackage

// File: rtl/apu_rob.sv
// Reorder buffer for in-flight APU operations.
// Slots are allocated at the tail in issue order, completed in any order by
// tagged responses, and retired from the head in issue order.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   alloc_i            allocate the tail slot (caller guarantees alloc_ok_o)
//   alloc_slot_o       slot index that the next allocation will use
//   alloc_ok_o         fewer than MAX_OUTSTANDING slots in use
//   rsp_valid_i/tag/data/flags  response from the APU
//   rsp_err_o          response present but unexpected (wrong core or slot)
//   ret_valid_o        head slot holds a completed result
//   ret_ready_i        consumer takes the head result
//   ret_data_o/flags_o head result payload
//   busy_o             at least one slot in use
module apu_rob
   import apu_pkg::*;
#(
   parameter int unsigned CORE_ID = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       alloc_i,
   output slot_t                      alloc_slot_o,
   output logic                       alloc_ok_o,
   input  logic                       rsp_valid_i,
   input  tag_t                       rsp_tag_i,
   input  logic [DATA_WIDTH-1:0]      rsp_data_i,
   input  logic [FLAGS_OUT_WIDTH-1:0] rsp_flags_i,
   output logic                       rsp_err_o,
   output logic                       ret_valid_o,
   input  logic                       ret_ready_i,
   output logic [DATA_WIDTH-1:0]      ret_data_o,
   output logic [FLAGS_OUT_WIDTH-1:0] ret_flags_o,
   output logic                       busy_o
);

   localparam core_t CORE_TAG = core_t'(CORE_ID);

   logic [MAX_OUTSTANDING-1:0] pending_q, pending_d;
   logic [MAX_OUTSTANDING-1:0] done_q, done_d;
   logic [DATA_WIDTH-1:0]      data_q  [MAX_OUTSTANDING];
   logic [FLAGS_OUT_WIDTH-1:0] flags_q [MAX_OUTSTANDING];
   slot_t                      head_q, head_d;
   slot_t                      tail_q, tail_d;
   cnt_t                       count_q, count_d;

   slot_t rsp_slot;
   logic  rsp_ok;
   logic  retire;

   always_comb begin
      rsp_slot     = tag_slot(rsp_tag_i);
      // A response is only taken for a slot of ours that is waiting for one.
      rsp_ok       = rsp_valid_i && (tag_core(rsp_tag_i) == CORE_TAG) &&
                     pending_q[rsp_slot] && !done_q[rsp_slot];
      rsp_err_o    = rsp_valid_i && !rsp_ok;
      ret_valid_o  = done_q[head_q];
      ret_data_o   = data_q[head_q];
      ret_flags_o  = flags_q[head_q];
      retire       = ret_valid_o && ret_ready_i;
      alloc_ok_o   = (count_q < cnt_t'(MAX_OUTSTANDING));
      alloc_slot_o = tail_q;
      busy_o       = (count_q != '0);

      pending_d = pending_q;
      done_d    = done_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;

      // The completing slot cannot be the retiring head (head is already
      // done), and the tail cannot alias a live head because alloc requires
      // a free slot, so these updates never collide.
      if (rsp_ok) begin
         done_d[rsp_slot] = 1'b1;
      end
      if (retire) begin
         pending_d[head_q] = 1'b0;
         done_d[head_q]    = 1'b0;
         head_d            = head_q + slot_t'(1);
      end
      if (alloc_i) begin
         pending_d[tail_q] = 1'b1;
         tail_d            = tail_q + slot_t'(1);
      end

      case ({alloc_i, retire})
         2'b10:   count_d = count_q + cnt_t'(1);
         2'b01:   count_d = count_q - cnt_t'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
         done_q    <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
            data_q[i]  <= '0;
            flags_q[i] <= '0;
         end
      end else begin
         pending_q <= pending_d;
         done_q    <= done_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         if (rsp_ok) begin
            data_q[rsp_slot]  <= rsp_data_i;
            flags_q[rsp_slot] <= rsp_flags_i;
         end
      end
   end

endmodule

// File: rtl/apu_req_issuer.sv
// Core-side APU/FPU request issuer.
// Accepts operations from dispatch, issues them on the APU req/gnt channel
// with a {CORE_ID, slot} tag, accepts out-of-order tagged responses and
// retires results to writeback in issue order via apu_rob.
// Handshakes: every channel transfers on a cycle where its valid (req) and
// its ready (gnt) are both high; a valid/req once raised holds its payload
// stable until that transfer cycle. The response channel is always ready.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid_i/req_ready_o        dispatch handshake
//   req_operands_i/op_i/flags_i    operation payload
//   resp_valid_o/resp_ready_i      in-order writeback handshake
//   resp_data_o/resp_flags_o       retired result and status flags
//   busy_o                         any operation in flight
//   err_o                          sticky, unexpected response seen
//   apu_req_o/apu_gnt_i            APU request channel
//   apu_ID_o/operands/op/flags_o   APU request payload
//   apu_rready_o                   constant 1
//   apu_rvalid_i/rdata/rflags/rID  APU response channel
module apu_req_issuer
   import apu_pkg::*;
#(
   parameter int unsigned CORE_ID = 0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            req_valid_i,
   output logic                            req_ready_o,
   input  logic [NB_ARGS*DATA_WIDTH-1:0]   req_operands_i,
   input  logic [OPCODE_WIDTH-1:0]         req_op_i,
   input  logic [FLAGS_IN_WIDTH-1:0]       req_flags_i,
   output logic                            resp_valid_o,
   input  logic                            resp_ready_i,
   output logic [DATA_WIDTH-1:0]           resp_data_o,
   output logic [FLAGS_OUT_WIDTH-1:0]      resp_flags_o,
   output logic                            busy_o,
   output logic                            err_o,
   output logic                            apu_req_o,
   input  logic                            apu_gnt_i,
   output logic [ID_WIDTH-1:0]             apu_ID_o,
   output logic [NB_ARGS*DATA_WIDTH-1:0]   apu_operands_o,
   output logic [OPCODE_WIDTH-1:0]         apu_op_o,
   output logic [FLAGS_IN_WIDTH-1:0]       apu_flags_o,
   output logic                            apu_rready_o,
   input  logic                            apu_rvalid_i,
   input  logic [DATA_WIDTH-1:0]           apu_rdata_i,
   input  logic [FLAGS_OUT_WIDTH-1:0]      apu_rflags_i,
   input  logic [ID_WIDTH-1:0]             apu_rID_i
);

   localparam core_t CORE_TAG = core_t'(CORE_ID);

   logic                          req_q, req_d;
   tag_t                          id_q, id_d;
   logic [NB_ARGS*DATA_WIDTH-1:0] operands_q, operands_d;
   logic [OPCODE_WIDTH-1:0]       op_q, op_d;
   logic [FLAGS_IN_WIDTH-1:0]     flags_q, flags_d;
   logic                          err_q, err_d;

   logic  accept;
   logic  alloc_ok;
   slot_t alloc_slot;
   logic  rsp_err;

   apu_rob #(
      .CORE_ID (CORE_ID)
   ) u_rob (
      .clk          (clk),
      .rst          (rst),
      .alloc_i      (accept),
      .alloc_slot_o (alloc_slot),
      .alloc_ok_o   (alloc_ok),
      .rsp_valid_i  (apu_rvalid_i),
      .rsp_tag_i    (apu_rID_i),
      .rsp_data_i   (apu_rdata_i),
      .rsp_flags_i  (apu_rflags_i),
      .rsp_err_o    (rsp_err),
      .ret_valid_o  (resp_valid_o),
      .ret_ready_i  (resp_ready_i),
      .ret_data_o   (resp_data_o),
      .ret_flags_o  (resp_flags_o),
      .busy_o       (busy_o)
   );

   always_comb begin
      // The request register frees up in the same cycle it is granted,
      // which gives back-to-back issue; this is the only comb input path.
      req_ready_o = !rst && (!req_q || apu_gnt_i) && alloc_ok;
      accept      = req_valid_i && req_ready_o;

      req_d      = req_q;
      id_d       = id_q;
      operands_d = operands_q;
      op_d       = op_q;
      flags_d    = flags_q;
      err_d      = err_q || rsp_err;

      if (accept) begin
         req_d      = 1'b1;
         id_d       = tag_compose(CORE_TAG, alloc_slot);
         operands_d = req_operands_i;
         op_d       = req_op_i;
         flags_d    = req_flags_i;
      end else if (apu_gnt_i) begin
         req_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_q      <= 1'b0;
         id_q       <= '0;
         operands_q <= '0;
         op_q       <= '0;
         flags_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         req_q      <= req_d;
         id_q       <= id_d;
         operands_q <= operands_d;
         op_q       <= op_d;
         flags_q    <= flags_d;
         err_q      <= err_d;
      end
   end

   assign apu_req_o      = req_q;
   assign apu_ID_o       = id_q;
   assign apu_operands_o = operands_q;
   assign apu_op_o       = op_q;
   assign apu_flags_o    = flags_q;
   assign apu_rready_o   = 1'b1;
   assign err_o          = err_q;

endmodule
